triangle_assembler: RTL
=======================

Name: triangle_assembler

Overview:
- Sits directly downstream of the vertex-to-viewport projection stage and upstream of the rasteriser setup.
- Collects three consecutive projected vertices into one triangle.
- Drops the whole triangle if any vertex was culled, or if the triangle is back-facing (when enabled).
- For surviving triangles, emits the three vertices with their screen-space bounding box and minimum depth, using a valid/ready handshake.

Parameters:
- X_WIDTH, 18, signed viewport x width.
- Y_WIDTH, 20, signed viewport y width.
- Z_WIDTH, 19, signed depth width.
- CULL_BACKFACE, 1, when 1, triangles with signed area <= 0 are dropped.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-high.
- valid_in  input  1  upstream vertex valid.
- ready_out  output  1  block can accept a vertex.
- cull_in  input  1  one-cycle strobe: the upstream vertex was culled (no handshake).
- x_in  input  X_WIDTH  vertex viewport x, signed.
- y_in  input  Y_WIDTH  vertex viewport y, signed.
- z_in  input  Z_WIDTH  vertex depth, signed.
- ready_in  input  1  downstream can accept a triangle.
- valid_out  output  1  triangle outputs valid.
- tri_x  output  3 x X_WIDTH  packed vertex x, index 0 = first vertex received.
- tri_y  output  3 x Y_WIDTH  packed vertex y.
- tri_z  output  3 x Z_WIDTH  packed vertex z.
- bb_xmin, bb_xmax  output  X_WIDTH  bounding box in x.
- bb_ymin, bb_ymax  output  Y_WIDTH  bounding box in y.
- z_min  output  Z_WIDTH  smallest vertex depth.
- tri_dropped  output  1  one-cycle pulse when a triangle is discarded.
- err_out  output  1  sticky: cull strobe lost.

Behaviour:
- Reset (async, any time, including mid-triangle):
  - state=COLLECT, vertex count=0, drop flag=0, pending cull=0.
  - valid_out=0, tri_dropped=0, err_out=0, all data outputs=0.
  - ready_out=1 (ready_out is combinational: high iff state==COLLECT).
  - Partially collected triangles are lost.
- States: COLLECT -> SETUP -> OUTPUT -> COLLECT.
- COLLECT:
  - Vertex event = (valid_in && ready_out) or cull_in. Both in the same cycle = one event, marked culled.
  - Non-culled event: store x/y/z in slot[count].
  - Culled event: set drop flag; slot contents are don't-care.
  - count increments on each event. On the third event (count==2):
    - If drop flag or this event is culled: pulse tri_dropped next cycle, clear count and drop flag, stay in COLLECT.
    - Otherwise go to SETUP.
- SETUP (exactly one cycle):
  - Register bounding box: min/max of 3 x, min/max of 3 y, signed compares.
  - Register z_min.
  - Compute area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) at full precision: (X_WIDTH+1)+(Y_WIDTH+1)+1 bits, no truncation.
  - If CULL_BACKFACE && area <= 0: pulse tri_dropped, return to COLLECT.
  - Otherwise go to OUTPUT.
- OUTPUT:
  - valid_out=1; outputs stable until the handshake.
  - On ready_in: valid_out falls next cycle, return to COLLECT, count=0.
  - ready_in already high on entry: valid_out is high for exactly one cycle.
- Latency: third vertex accepted at cycle t -> valid_out high at t+2 (minimum). Throughput: one triangle per 5 cycles minimum.
- cull_in outside COLLECT:
  - If pending cull=0: set pending cull=1. On return to COLLECT it is consumed as the first event of the next triangle (count=1, drop flag=1) in that first COLLECT cycle; valid_in is blocked that cycle.
  - If pending cull is already 1: set err_out; the strobe is discarded.
- tri_dropped and valid_out are never high together.

Test Plan:
- Vertices (0,0,5),(10,0,7),(0,10,3), ready_in=1 -> valid_out at t+2 for one cycle; bbox x 0..10, y 0..10; z_min=3; tri_x={0,10,0}.
- Same vertices in clockwise order (0,0),(0,10),(10,0) with CULL_BACKFACE=1 -> tri_dropped pulse, no valid_out; with CULL_BACKFACE=0 -> triangle emitted.
- Valid vertex, cull_in strobe, valid vertex -> tri_dropped one cycle after the third event; next three valid vertices emit normally.
- ready_in held low 20 cycles -> valid_out and outputs stable, ready_out=0; release -> valid_out drops next cycle, ready_out=1.
- Two cull_in strobes during OUTPUT -> err_out=1 and sticky; next triangle starts with count=1 and is dropped.
- Reset asserted after two vertices collected -> outputs cleared immediately; the next three vertices form a fresh triangle with correct values.
- valid_in and cull_in in the same cycle -> counts as one culled vertex.

Source files
------------

// File: rtl/triangle_assembler.sv
// Triangle assembler: gathers three projected vertices, culls, and
// emits surviving triangles with bounding box and minimum depth.
module triangle_assembler #(
  parameter int X_WIDTH       = 18,
  parameter int Y_WIDTH       = 20,
  parameter int Z_WIDTH       = 19,
  parameter bit CULL_BACKFACE = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 cull_in,
  input  logic [X_WIDTH-1:0]   x_in,
  input  logic [Y_WIDTH-1:0]   y_in,
  input  logic [Z_WIDTH-1:0]   z_in,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [3*X_WIDTH-1:0] tri_x,
  output logic [3*Y_WIDTH-1:0] tri_y,
  output logic [3*Z_WIDTH-1:0] tri_z,
  output logic [X_WIDTH-1:0]   bb_xmin,
  output logic [X_WIDTH-1:0]   bb_xmax,
  output logic [Y_WIDTH-1:0]   bb_ymin,
  output logic [Y_WIDTH-1:0]   bb_ymax,
  output logic [Z_WIDTH-1:0]   z_min,
  output logic                 tri_dropped,
  output logic                 err_out
);

  localparam int AW = X_WIDTH + Y_WIDTH + 3;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  logic [1:0] state;
  logic [1:0] cnt;
  logic       drop;
  logic       pend;

  logic signed [X_WIDTH-1:0] sx [3];
  logic signed [Y_WIDTH-1:0] sy [3];
  logic signed [Z_WIDTH-1:0] sz [3];

  logic signed [X_WIDTH-1:0] xmn, xmx;
  logic signed [Y_WIDTH-1:0] ymn, ymx;
  logic signed [Z_WIDTH-1:0] zmn;

  logic signed [X_WIDTH:0] dx1, dx2;
  logic signed [Y_WIDTH:0] dy1, dy2;
  logic signed [AW-1:0]    area;

  logic ev;
  logic ev_cull;
  logic acc;

  // A pending cull owns the first collect cycle, so hold off vertices then
  assign ready_out = (state == COLLECT) && !pend;
  assign valid_out = (state == OUTPUT);
  assign acc       = valid_in && ready_out;
  assign ev        = (state == COLLECT) && (pend || acc || cull_in);
  assign ev_cull   = pend || cull_in;

  // Pack the vertex slots, slot 0 in the low bits
  always_comb begin
    tri_x = '0;
    tri_y = '0;
    tri_z = '0;
    for (int i = 0; i < 3; i++) begin
      tri_x[i*X_WIDTH +: X_WIDTH] = sx[i];
      tri_y[i*Y_WIDTH +: Y_WIDTH] = sy[i];
      tri_z[i*Z_WIDTH +: Z_WIDTH] = sz[i];
    end
  end

  // Signed extrema over the three stored vertices
  always_comb begin
    xmn = sx[0];
    xmx = sx[0];
    ymn = sy[0];
    ymx = sy[0];
    zmn = sz[0];
    for (int i = 1; i < 3; i++) begin
      if (sx[i] < xmn) xmn = sx[i];
      if (sx[i] > xmx) xmx = sx[i];
      if (sy[i] < ymn) ymn = sy[i];
      if (sy[i] > ymx) ymx = sy[i];
      if (sz[i] < zmn) zmn = sz[i];
    end
  end

  // Full-precision doubled signed area; positive means counter-clockwise
  always_comb begin
    dx1  = (X_WIDTH+1)'(sx[1]) - (X_WIDTH+1)'(sx[0]);
    dx2  = (X_WIDTH+1)'(sx[2]) - (X_WIDTH+1)'(sx[0]);
    dy1  = (Y_WIDTH+1)'(sy[1]) - (Y_WIDTH+1)'(sy[0]);
    dy2  = (Y_WIDTH+1)'(sy[2]) - (Y_WIDTH+1)'(sy[0]);
    area = AW'(dx1) * AW'(dy2) - AW'(dx2) * AW'(dy1);
  end

  // Control: vertex counting, drop decisions, handshake, pending cull
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= COLLECT;
      cnt         <= 2'd0;
      drop        <= 1'b0;
      pend        <= 1'b0;
      tri_dropped <= 1'b0;
      err_out     <= 1'b0;
    end else begin
      tri_dropped <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (pend) pend <= cull_in;
          if (ev) begin
            if (cnt == 2'd2) begin
              cnt  <= 2'd0;
              drop <= 1'b0;
              if (drop || ev_cull) tri_dropped <= 1'b1;
              else                 state       <= SETUP;
            end else begin
              cnt <= cnt + 2'd1;
              if (ev_cull) drop <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (CULL_BACKFACE && area <= 0) begin
            tri_dropped <= 1'b1;
            state       <= COLLECT;
          end else begin
            state <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (ready_in) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
      if (state != COLLECT && cull_in) begin
        if (pend) err_out <= 1'b1;
        else      pend    <= 1'b1;
      end
    end
  end

  // Datapath: vertex slots and setup results
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 3; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
        sz[i] <= '0;
      end
      bb_xmin <= '0;
      bb_xmax <= '0;
      bb_ymin <= '0;
      bb_ymax <= '0;
      z_min   <= '0;
    end else begin
      if (ev && !ev_cull) begin
        sx[cnt] <= x_in;
        sy[cnt] <= y_in;
        sz[cnt] <= z_in;
      end
      if (state == SETUP) begin
        bb_xmin <= xmn;
        bb_xmax <= xmx;
        bb_ymin <= ymn;
        bb_ymax <= ymx;
        z_min   <= zmn;
      end
    end
  end

endmodule
